// File: rtl/windowed_winner_select.sv
// Windowed winner-take-all readout: counts spikes per output node over a fixed window,
// scans the counters for the argmax and offers the winning index on a valid/ready port.
module windowed_winner_select #(
    parameter int NUM_NODES  = 10,
    parameter int CNT_W      = 16,
    parameter int WINDOW_LEN = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_NODES-1:0]          nodes_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [$clog2(NUM_NODES):0]    winner_o,
    output logic [CNT_W-1:0]              max_count_o,
    output logic                          tie_o,
    output logic                          none_o,
    output logic                          res_valid_o,
    input  logic                          res_ready_i
);
    localparam int IDX_W  = $clog2(NUM_NODES) + 1;
    localparam int STEP_W = $clog2(WINDOW_LEN + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_NODES - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {S_COUNT, S_SCAN, S_RESULT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NUM_NODES];
    logic [CNT_W-1:0]  cnt_d [NUM_NODES];
    logic [STEP_W-1:0] step_q, step_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  best_q, best_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic              tie_q, tie_d;

    logic              accept;
    logic              window_done;
    logic              scan_done;
    logic              res_fire;
    logic [CNT_W-1:0]  scan_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != CNT_MAX)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    always_comb begin
        accept      = valid_i && (state_q == S_COUNT);
        window_done = accept && (step_q == LAST_STEP);
        scan_done   = (state_q == S_SCAN) && (idx_q == LAST_IDX);
        res_fire    = (state_q == S_RESULT) && res_ready_i;
    end

    // Counter select by comparison keeps the index width independent of the array depth.
    always_comb begin
        scan_cnt = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                scan_cnt = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_COUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COUNT:  if (window_done) state_d = S_SCAN;
            S_SCAN:   if (scan_done)   state_d = S_RESULT;
            S_RESULT: if (res_ready_i) state_d = S_COUNT;
            default:  state_d = S_COUNT;
        endcase
    end

    always_comb begin
        ready_o     = (state_q == S_COUNT);
        res_valid_o = (state_q == S_RESULT);
        winner_o    = '0;
        max_count_o = '0;
        tie_o       = 1'b0;
        none_o      = 1'b0;
        if (state_q == S_RESULT) begin
            winner_o    = best_idx_q;
            max_count_o = best_q;
            tie_o       = tie_q && (best_q != '0);
            none_o      = (best_q == '0);
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        step_d     = step_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        tie_d      = tie_q;
        if (accept) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                cnt_d[i] = sat_inc(cnt_q[i], nodes_i[i]);
            end
            step_d = window_done ? '0 : step_q + STEP_W'(1);
        end
        // Strict greater-than keeps the lowest index on equal counts.
        if (state_q == S_SCAN) begin
            idx_d = scan_done ? '0 : idx_q + IDX_W'(1);
            if (idx_q == '0) begin
                best_d     = scan_cnt;
                best_idx_d = '0;
                tie_d      = 1'b0;
            end else if (scan_cnt > best_q) begin
                best_d     = scan_cnt;
                best_idx_d = idx_q;
                tie_d      = 1'b0;
            end else if (scan_cnt == best_q) begin
                tie_d      = 1'b1;
            end
        end
        if (res_fire) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                cnt_d[i] = '0;
            end
            step_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                cnt_q[i] <= '0;
            end
            step_q     <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            tie_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            tie_q      <= tie_d;
        end
    end
endmodule

// File: tb/tb_windowed_winner_select.sv
// Bench for windowed_winner_select: two instances (wide counters / narrow saturating
// counters) share one stimulus stream and are compared every cycle against a window model.
module tb_windowed_winner_select;
    localparam int NN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [NN-1:0] nodes;
    logic          valid;
    logic          rres;

    logic        a_ready, a_tie, a_none, a_rv;
    logic [2:0]  a_win;
    logic [15:0] a_max;
    logic        b_ready, b_tie, b_none, b_rv;
    logic [2:0]  b_win;
    logic [2:0]  b_max;

    windowed_winner_select #(.NUM_NODES(NN), .CNT_W(16), .WINDOW_LEN(8)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .nodes_i(nodes), .valid_i(valid), .ready_o(a_ready),
        .winner_o(a_win), .max_count_o(a_max), .tie_o(a_tie), .none_o(a_none),
        .res_valid_o(a_rv), .res_ready_i(rres)
    );

    windowed_winner_select #(.NUM_NODES(NN), .CNT_W(3), .WINDOW_LEN(12)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .nodes_i(nodes), .valid_i(valid), .ready_o(b_ready),
        .winner_o(b_win), .max_count_o(b_max), .tie_o(b_tie), .none_o(b_none),
        .res_valid_o(b_rv), .res_ready_i(rres)
    );

    int checks = 0;
    int errors = 0;

    // Model: per instance, spike counts of the open window, accepted steps, and
    // cycles elapsed since the window closed (0 while counting).
    int m_cnt [2][NN];
    int m_steps [2];
    int m_d [2];

    function automatic int wl(input int u);
        return (u == 0) ? 8 : 12;
    endfunction

    function automatic int satv(input int u);
        return (u == 0) ? 65535 : 7;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void exp_res(input int u, output int w, output int mx, output int tie);
        int ties;
        mx = -1;
        w = 0;
        ties = 0;
        for (int n = 0; n < NN; n++) begin
            if (m_cnt[u][n] > mx) begin
                mx = m_cnt[u][n];
                w = n;
            end
        end
        for (int n = 0; n < NN; n++) begin
            if (m_cnt[u][n] == mx) ties++;
        end
        tie = ((ties > 1) && (mx != 0)) ? 1 : 0;
    endfunction

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_steps[u] = 0;
            m_d[u] = 0;
            for (int n = 0; n < NN; n++) m_cnt[u][n] = 0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                int w, mx, t;
                int rdy, rv, aw, amx, at, an;
                rdy = (u == 0) ? int'(a_ready) : int'(b_ready);
                rv  = (u == 0) ? int'(a_rv)    : int'(b_rv);
                aw  = (u == 0) ? int'(a_win)   : int'(b_win);
                amx = (u == 0) ? int'(a_max)   : int'(b_max);
                at  = (u == 0) ? int'(a_tie)   : int'(b_tie);
                an  = (u == 0) ? int'(a_none)  : int'(b_none);
                chk($sformatf("ready_%0d", u), rdy, (m_d[u] == 0) ? 1 : 0);
                chk($sformatf("res_valid_%0d", u), rv, (m_d[u] == NN + 1) ? 1 : 0);
                if (m_d[u] == NN + 1) begin
                    exp_res(u, w, mx, t);
                    chk($sformatf("winner_%0d", u), aw, w);
                    chk($sformatf("max_count_%0d", u), amx, mx);
                    chk($sformatf("tie_%0d", u), at, t);
                    chk($sformatf("none_%0d", u), an, (mx == 0) ? 1 : 0);
                end
            end
            // Advance using the inputs the coming clock edge will sample.
            for (int u = 0; u < 2; u++) begin
                if (!rst_n) begin
                    m_d[u] = 0;
                    m_steps[u] = 0;
                    for (int n = 0; n < NN; n++) m_cnt[u][n] = 0;
                end else if (m_d[u] == 0) begin
                    if (valid) begin
                        for (int n = 0; n < NN; n++) begin
                            if (nodes[n] && (m_cnt[u][n] < satv(u))) m_cnt[u][n]++;
                        end
                        m_steps[u]++;
                        if (m_steps[u] == wl(u)) begin
                            m_steps[u] = 0;
                            m_d[u] = 1;
                        end
                    end
                end else if (m_d[u] <= NN) begin
                    m_d[u]++;
                end else if (rres) begin
                    m_d[u] = 0;
                    for (int n = 0; n < NN; n++) m_cnt[u][n] = 0;
                end
            end
        end
    end

    function automatic logic [NN-1:0] pat_vec(input int pat, input int s);
        case (pat)
            0:       return 4'b0100;
            1:       return (s < 3) ? 4'b1011 : ((s < 5) ? 4'b1010 : 4'b0000);
            3:       return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic run_window(input int pat);
        int s;
        s = 0;
        while (s < 12) begin
            @(posedge clk); #1;
            if ($urandom_range(3) == 0) begin
                valid = 1'b0;
                nodes = 4'b1111;
            end else begin
                valid = 1'b1;
                nodes = pat_vec(pat, s);
                s++;
            end
        end
        @(posedge clk); #1;
        valid = 1'b0;
        nodes = '0;
    endtask

    task automatic wait_res(input int u, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = (u == 0) ? a_rv : b_rv;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s res_valid actual=0 expected=1 within 200 cycles", tag);
        end
    endtask

    task automatic handshake();
        @(posedge clk); #1 rres = 1'b1;
        @(posedge clk); #1 rres = 1'b0;
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        valid = 1'b0;
        nodes = '0;
        rres  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", a_ready, 1);
        chk("rst_res_valid", a_rv, 0);
        chk("rst_winner", a_win, 0);
        chk("rst_max", a_max, 0);
        chk("rst_tie", a_tie, 0);
        chk("rst_none", a_none, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single dominant node; narrow instance saturates at 7.
        run_window(0);
        wait_res(0, "t1_a");
        chk("t1_a_win", a_win, 2); chk("t1_a_max", a_max, 8);
        chk("t1_a_tie", a_tie, 0); chk("t1_a_none", a_none, 0);
        wait_res(1, "t1_b");
        chk("t1_b_win", b_win, 2); chk("t1_b_max", b_max, 7);
        handshake();

        // Tie between nodes 1 and 3; result held with valid pulses ignored.
        run_window(1);
        wait_res(0, "t2_a");
        wait_res(1, "t2_b");
        chk("t2_a_win", a_win, 1); chk("t2_a_max", a_max, 5); chk("t2_a_tie", a_tie, 1);
        chk("t2_b_win", b_win, 1); chk("t2_b_tie", b_tie, 1);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            valid = k[0];
            nodes = 4'b1111;
        end
        @(negedge clk);
        chk("t4_hold_win", a_win, 1); chk("t4_hold_max", a_max, 5); chk("t4_hold_ready", a_ready, 0);
        valid = 1'b0;
        handshake();
        @(negedge clk);
        chk("t4_ready_after", a_ready, 1);

        // Silent window.
        run_window(2);
        wait_res(0, "t3_a");
        wait_res(1, "t3_b");
        chk("t3_a_win", a_win, 0); chk("t3_a_none", a_none, 1);
        chk("t3_a_tie", a_tie, 0); chk("t3_a_max", a_max, 0);
        chk("t3_b_none", b_none, 1);
        handshake();

        // Saturation without wrap on the narrow instance.
        run_window(3);
        wait_res(0, "t5_a");
        wait_res(1, "t5_b");
        chk("t5_a_max", a_max, 8); chk("t5_b_max", b_max, 7);
        chk("t5_b_win", b_win, 0); chk("t5_b_tie", b_tie, 0);
        handshake();

        // Reset during the scan discards that window.
        @(posedge clk); #1;
        valid = 1'b1;
        nodes = 4'b0100;
        repeat (8) @(posedge clk);
        #1;
        valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (a_rv) seen = 1'b1;
        end
        chk("t6_no_result", seen, 0);
        run_window(0);
        wait_res(0, "t6_a");
        chk("t6_a_win", a_win, 2); chk("t6_a_max", a_max, 8);
        wait_res(1, "t6_b");
        handshake();

        repeat (3000) begin
            @(posedge clk); #1;
            valid = ($urandom_range(9) < 7);
            nodes = 4'($urandom);
            rres  = ($urandom_range(3) == 0);
            rst_n = ($urandom_range(299) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        valid = 1'b0;
        rres  = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
